// File: rtl/score_keeper.sv
// Game score accumulator with combo tracking and a sequential double-dabble
// binary-to-BCD converter feeding the score display.
module score_keeper #(
    parameter int unsigned PERFECT_PTS = 100,
    parameter int unsigned GOOD_PTS    = 50,
    parameter int unsigned COMBO_STEP  = 10,
    parameter int unsigned MAX_MULT    = 4,
    parameter int unsigned SCORE_MAX   = 99999999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        hit_valid,
    input  logic [1:0]  hit_grade,
    output logic [31:0] score,
    output logic [31:0] score_bcd,
    output logic [15:0] combo,
    output logic [15:0] max_combo,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [27:0] SCORE_MAX_W = 28'(SCORE_MAX);

    state_t      state_q, state_d;
    logic [26:0] score_q, score_d;
    logic [15:0] combo_q, combo_d;
    logic [15:0] max_combo_q, max_combo_d;
    logic [31:0] score_bcd_q, score_bcd_d;
    logic        dirty_q, dirty_d;
    logic [26:0] bin_q, bin_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;

    logic        hit_ok;
    logic [15:0] quot;
    logic [2:0]  mult;
    logic [27:0] points;
    logic [27:0] sum;
    logic [27:0] capped;
    logic [15:0] combo_inc;
    logic [31:0] acc_adj;

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        combo_d     = combo_q;
        max_combo_d = max_combo_q;
        score_bcd_d = score_bcd_q;
        dirty_d     = dirty_q;
        bin_d       = bin_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;

        hit_ok = hit_valid && (hit_grade != 2'b11);

        // Multiplier from pre-update combo, capped at MAX_MULT
        quot = combo_q / 16'(COMBO_STEP);
        if (quot >= 16'(MAX_MULT - 1)) begin
            mult = 3'(MAX_MULT);
        end else begin
            mult = 3'(quot) + 3'd1;
        end

        points    = (hit_grade == 2'b10) ? 28'(PERFECT_PTS) : 28'(GOOD_PTS);
        points    = points * 28'(mult);
        sum       = {1'b0, score_q} + points;
        capped    = (sum > SCORE_MAX_W) ? SCORE_MAX_W : sum;
        combo_inc = (combo_q == 16'hFFFF) ? combo_q : combo_q + 16'd1;

        acc_adj = acc_q;
        for (int i = 0; i < 8; i++) begin
            if (acc_q[i*4 +: 4] >= 4'd5) begin
                acc_adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (dirty_q) begin
                    bin_d   = score_q;
                    acc_d   = '0;
                    dirty_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                acc_d = {acc_adj[30:0], bin_q[26]};
                bin_d = {bin_q[25:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd26) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                score_bcd_d = acc_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Hit handling after the FSM so a new score change re-arms dirty
        if (hit_ok) begin
            if (hit_grade == 2'b00) begin
                combo_d = '0;
            end else begin
                score_d     = capped[26:0];
                combo_d     = combo_inc;
                max_combo_d = (combo_inc > max_combo_q) ? combo_inc : max_combo_q;
                if (capped[26:0] != score_q) begin
                    dirty_d = 1'b1;
                end
            end
        end

        if (clear) begin
            state_d     = S_IDLE;
            score_d     = '0;
            combo_d     = '0;
            max_combo_d = '0;
            score_bcd_d = '0;
            dirty_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            score_q     <= '0;
            combo_q     <= '0;
            max_combo_q <= '0;
            score_bcd_q <= '0;
            dirty_q     <= 1'b0;
            bin_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            combo_q     <= combo_d;
            max_combo_q <= max_combo_d;
            score_bcd_q <= score_bcd_d;
            dirty_q     <= dirty_d;
            bin_q       <= bin_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign score     = {5'b0, score_q};
    assign score_bcd = score_bcd_q;
    assign combo     = combo_q;
    assign max_combo = max_combo_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper: default instance plus a
// saturation instance with SCORE_MAX=1000, MAX_MULT=1.
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        hit_valid;
    logic [1:0]  hit_grade;
    logic [31:0] score, score_bcd;
    logic [15:0] combo, max_combo;
    logic        busy;

    logic        s_hit_valid;
    logic [1:0]  s_hit_grade;
    logic [31:0] s_score, s_score_bcd;
    logic [15:0] s_combo, s_max_combo;
    logic        s_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    score_keeper u_dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .hit_valid (hit_valid),
        .hit_grade (hit_grade),
        .score     (score),
        .score_bcd (score_bcd),
        .combo     (combo),
        .max_combo (max_combo),
        .busy      (busy)
    );

    score_keeper #(.SCORE_MAX(1000), .MAX_MULT(1)) u_sat (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .hit_valid (s_hit_valid),
        .hit_grade (s_hit_grade),
        .score     (s_score),
        .score_bcd (s_score_bcd),
        .combo     (s_combo),
        .max_combo (s_max_combo),
        .busy      (s_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int i = 0; i < 300 && quiet < 2; i++) begin
            tick();
            if (!busy && !s_busy) quiet++;
            else quiet = 0;
        end
        chk("wait_idle_bound", quiet, 2);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        int nchg;
        logic [31:0] prev_bcd;
        logic [31:0] first_val;

        rst = 1'b1; clear = 1'b0;
        hit_valid = 1'b0; hit_grade = 2'b00;
        s_hit_valid = 1'b0; s_hit_grade = 2'b00;
        #12;
        chk("rst_score", score, 0);
        chk("rst_bcd", score_bcd, 0);
        chk("rst_combo", {16'b0, combo}, 0);
        chk("rst_max", {16'b0, max_combo}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rel_busy", {31'b0, busy}, 0);

        // Single perfect and conversion latency
        hit_valid = 1'b1; hit_grade = 2'b10;
        tick();
        hit_valid = 1'b0;
        chk("single_score", score, 100);
        chk("single_combo", {16'b0, combo}, 1);
        chk("single_busy_e0", {31'b0, busy}, 0);
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 1)  chk("single_busy_e1", {31'b0, busy}, 1);
            if (k == 28) begin
                chk("single_busy_done", {31'b0, busy}, 1);
                chk("single_bcd_e28", score_bcd, 0);
            end
            if (k == 29) chk("single_bcd_e29", score_bcd, 32'h0000_0100);
            if (k == 30) chk("single_busy_e30", {31'b0, busy}, 0);
        end

        // Multiplier steps
        pulse_clear();
        chk("clr_score", score, 0);
        chk("clr_bcd", score_bcd, 0);
        hit_valid = 1'b1; hit_grade = 2'b10;
        for (int i = 0; i < 10; i++) tick();
        chk("mult_score10", score, 1000);
        chk("mult_combo10", {16'b0, combo}, 10);
        tick();
        chk("mult_score11", score, 1200);
        chk("mult_combo11", {16'b0, combo}, 11);
        hit_grade = 2'b00;
        tick();
        chk("miss_combo", {16'b0, combo}, 0);
        chk("miss_max", {16'b0, max_combo}, 11);
        chk("miss_score", score, 1200);
        hit_grade = 2'b11;
        tick();
        hit_valid = 1'b0;
        chk("rsv_score", score, 1200);
        chk("rsv_combo", {16'b0, combo}, 0);
        chk("rsv_max", {16'b0, max_combo}, 11);
        wait_idle();
        chk("mult_bcd", score_bcd, 32'h0000_1200);

        // Burst during conversion
        pulse_clear();
        wait_idle();
        nchg = 0;
        first_val = '0;
        prev_bcd = score_bcd;
        for (int i = 0; i < 80; i++) begin
            hit_valid = (i == 0) || (i >= 3 && i <= 7);
            hit_grade = (i == 0) ? 2'b10 : 2'b01;
            tick();
            if (score_bcd !== prev_bcd) begin
                nchg++;
                if (nchg == 1) first_val = score_bcd;
                prev_bcd = score_bcd;
            end
        end
        hit_valid = 1'b0;
        chk("burst_nconv", nchg, 2);
        chk("burst_first", first_val, 32'h0000_0100);
        chk("burst_bcd", score_bcd, 32'h0000_0350);
        chk("burst_score", score, 350);
        chk("burst_combo", {16'b0, combo}, 6);

        // Clear with coincident hit during SHIFT
        hit_valid = 1'b1; hit_grade = 2'b10;
        tick();
        hit_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("cs_busy_before", {31'b0, busy}, 1);
        clear = 1'b1; hit_valid = 1'b1; hit_grade = 2'b10;
        tick();
        clear = 1'b0; hit_valid = 1'b0;
        chk("cs_score", score, 0);
        chk("cs_combo", {16'b0, combo}, 0);
        chk("cs_max", {16'b0, max_combo}, 0);
        chk("cs_bcd", score_bcd, 0);
        chk("cs_busy", {31'b0, busy}, 0);
        tick();
        chk("cs_busy_after", {31'b0, busy}, 0);
        hit_valid = 1'b1; hit_grade = 2'b10;
        tick();
        hit_valid = 1'b0;
        chk("cs_next_score", score, 100);
        wait_idle();
        chk("cs_next_bcd", score_bcd, 32'h0000_0100);

        // Saturation instance
        s_hit_valid = 1'b1; s_hit_grade = 2'b10;
        for (int i = 0; i < 10; i++) tick();
        s_hit_valid = 1'b0;
        chk("sat_score10", s_score, 1000);
        wait_idle();
        chk("sat_bcd", s_score_bcd, 32'h0000_1000);
        s_hit_valid = 1'b1;
        tick();
        s_hit_valid = 1'b0;
        chk("sat_score11", s_score, 1000);
        chk("sat_combo11", {16'b0, s_combo}, 11);
        tick();
        chk("sat_no_restart1", {31'b0, s_busy}, 0);
        tick();
        chk("sat_no_restart2", {31'b0, s_busy}, 0);

        // Asynchronous reset mid-conversion
        hit_valid = 1'b1; hit_grade = 2'b01;
        tick();
        hit_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("ar_busy_before", {31'b0, busy}, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_score", score, 0);
        chk("ar_bcd", score_bcd, 0);
        chk("ar_combo", {16'b0, combo}, 0);
        chk("ar_max", {16'b0, max_combo}, 0);
        chk("ar_busy", {31'b0, busy}, 0);
        chk("ar_sat_score", s_score, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("ar_busy_rel", {31'b0, busy}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
